jtag_host_seq: RTL



---
 rtl/jtag_pkg.sv | 91 +++++++++
 rtl/jtag_host_seq_if.sv | 22 ++
 rtl/tap_shadow.sv | 28 ++
 rtl/jtag_host_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, command opcodes, sequencer states
// and the TAP next-state function used by the shadow and the sequencer.
package jtag_pkg;

    localparam int unsigned MAX_LEN   = 32;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned RESET_LEN = 5;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_IDLE  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_PRE   = 3'd1,
        SEQ_NAV   = 3'd2,
        SEQ_SHIFT = 3'd3,
        SEQ_POST  = 3'd4,
        SEQ_WAIT  = 3'd5
    } seq_state_e;

    // IEEE 1149.1 TAP transition function
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: n = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: n = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: n = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: n = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: n = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: n = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: n = tms ? TAP_SELDR : TAP_RTI;
            default:   n = TAP_TLR;
        endcase
        return n;
    endfunction

    function automatic logic is_shift(input tap_state_e s);
        return (s == TAP_SHIR) || (s == TAP_SHDR);
    endfunction

    function automatic logic is_exit1(input tap_state_e s);
        return (s == TAP_EX1IR) || (s == TAP_EX1DR);
    endfunction

    // Zero means one bit; anything beyond the scan width saturates
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        if (len == '0) begin
            r = LEN_W'(1);
        end else if (len > LEN_W'(MAX_LEN)) begin
            r = LEN_W'(MAX_LEN);
        end else begin
            r = len;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtag_host_seq_if.sv
// Command/response handshake between the test/config master and the JTAG sequencer.
interface jtag_host_seq_if;

    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [1:0]                      cmd_op;
    logic [jtag_pkg::LEN_W-1:0]      cmd_len;
    logic [jtag_pkg::MAX_LEN-1:0]    cmd_data;
    logic                            rsp_valid;
    logic [jtag_pkg::MAX_LEN-1:0]    rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/tap_shadow.sv
// Shadow copy of the target TAP controller state, advanced by the tms we drive.
module tap_shadow
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       por_i,
    input  logic       tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_comb begin
        state_d = tap_next(state_q, tms_i);
    end

    always_ff @(posedge tck_i) begin
        if (por_i) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_host_seq.sv
// Host-side JTAG sequencer: walks the target TAP through reset, IR/DR scans and
// idle cycles, one command at a time, collecting tdo during the shift window.
module jtag_host_seq
    import jtag_pkg::*;
(
    input  logic                tck,
    input  logic                por,
    jtag_host_seq_if.slave      cmd,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic [3:0]          tap_state,
    output logic                busy
);

    seq_state_e         st_q;
    cmd_op_e            op_q;
    logic [LEN_W-1:0]   nlen_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [MAX_LEN-1:0] sr_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               rsp_valid_q;
    logic               tms_q;
    logic               tdi_q;
    logic               busy_q;
    logic               rdy_q;

    tap_state_e         shadow;
    tap_state_e         shadow_nx;
    cmd_op_e            cmd_op_in;

    tap_shadow u_shadow (
        .tck_i   (tck),
        .por_i   (por),
        .tms_i   (tms_q),
        .state_o (shadow)
    );

    // State the target enters on the coming edge; tms/tdi are chosen for it
    always_comb begin
        shadow_nx = tap_next(shadow, tms_q);
        cmd_op_in = cmd_op_e'(cmd.cmd_op);
    end

    always_ff @(posedge tck) begin
        if (por) begin
            st_q        <= SEQ_IDLE;
            op_q        <= OP_RESET;
            nlen_q      <= LEN_W'(1);
            cnt_q       <= '0;
            sr_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            tdi_q       <= 1'b0;
            case (st_q)
                SEQ_IDLE: begin
                    // Park: hold TLR with tms=1, hold RTI with tms=0
                    tms_q <= (shadow_nx == TAP_TLR);
                    if (cmd.cmd_valid && rdy_q) begin
                        op_q   <= cmd_op_in;
                        nlen_q <= clamp_len(cmd.cmd_len);
                        sr_q   <= cmd.cmd_data;
                        cap_q  <= '0;
                        cnt_q  <= LEN_W'(1);
                        busy_q <= 1'b1;
                        rdy_q  <= 1'b0;
                        if (cmd_op_in == OP_RESET) begin
                            st_q  <= SEQ_NAV;
                            tms_q <= 1'b1;
                        end else if (shadow_nx == TAP_TLR) begin
                            st_q  <= SEQ_PRE;
                            tms_q <= 1'b0;
                        end else if (cmd_op_in == OP_IDLE) begin
                            st_q  <= SEQ_WAIT;
                            tms_q <= 1'b0;
                        end else begin
                            st_q  <= SEQ_NAV;
                            tms_q <= 1'b1;
                        end
                    end
                end

                SEQ_PRE: begin
                    cnt_q <= LEN_W'(1);
                    if (op_q == OP_IDLE) begin
                        st_q  <= SEQ_WAIT;
                        tms_q <= 1'b0;
                    end else begin
                        st_q  <= SEQ_NAV;
                        tms_q <= 1'b1;
                    end
                end

                SEQ_WAIT: begin
                    if (cnt_q == nlen_q) begin
                        st_q        <= SEQ_IDLE;
                        busy_q      <= 1'b0;
                        rdy_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        tms_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        tms_q <= 1'b0;
                    end
                end

                SEQ_NAV: begin
                    if (op_q == OP_RESET) begin
                        if (cnt_q == LEN_W'(RESET_LEN)) begin
                            st_q  <= SEQ_POST;
                            tms_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                            tms_q <= 1'b1;
                        end
                    end else if (is_shift(shadow_nx)) begin
                        st_q  <= SEQ_SHIFT;
                        cnt_q <= '0;
                        tms_q <= (nlen_q == LEN_W'(1));
                        tdi_q <= sr_q[0];
                        sr_q  <= sr_q >> 1;
                    end else begin
                        // SelDR -> SelIR only for IR scans; Capture -> Shift always
                        tms_q <= (shadow_nx == TAP_SELDR) && (op_q == OP_IR);
                    end
                end

                SEQ_SHIFT: begin
                    cap_q[cnt_q[IDX_W-1:0]] <= tdo;
                    if (cnt_q == nlen_q - LEN_W'(1)) begin
                        st_q  <= SEQ_POST;
                        tms_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        tdi_q <= sr_q[0];
                        sr_q  <= sr_q >> 1;
                        tms_q <= (cnt_q + LEN_W'(2) == nlen_q);
                    end
                end

                SEQ_POST: begin
                    if (shadow_nx == TAP_RTI) begin
                        st_q        <= SEQ_IDLE;
                        busy_q      <= 1'b0;
                        rdy_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (op_q == OP_RESET) ? '0 : cap_q;
                        tms_q       <= 1'b0;
                    end else begin
                        tms_q <= is_exit1(shadow_nx);
                    end
                end

                default: begin
                    st_q <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign busy          = busy_q;
    assign tap_state     = shadow;
    assign cmd.cmd_ready = rdy_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;

endmodule
